// File: rtl/pwm_multi_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : pwm_multi_channel
//  Description : Multi-channel PWM generator. One prescaler and one period
//                counter are shared by all channels. Supports edge- or
//                center-aligned counting, per-channel polarity and
//                double-buffered duty values that update at period boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_multi_channel #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic [PRESCALE_W-1:0]   prescale,
    input  logic [WIDTH-1:0]        period,
    input  logic                    center_mode,
    input  logic                    duty_wr,
    input  logic [NUM_CH*WIDTH-1:0] duty_in,
    input  logic [NUM_CH-1:0]       polarity,
    output logic [NUM_CH-1:0]       pwm_out,
    output logic                    period_start,
    output logic                    update_pending
);

    localparam logic [WIDTH-1:0]      c_CNT_ONE   = WIDTH'(1);
    localparam logic [PRESCALE_W-1:0] c_PRESC_ONE = PRESCALE_W'(1);

    logic [PRESCALE_W-1:0]   r_presc_cnt;
    logic [WIDTH-1:0]        r_cnt;
    logic                    r_dir_down;
    logic [WIDTH-1:0]        r_period;
    logic                    r_center;
    logic [NUM_CH*WIDTH-1:0] r_shadow;
    logic [NUM_CH*WIDTH-1:0] r_active;
    logic                    r_pending;
    logic                    r_period_start;
    logic [NUM_CH-1:0]       r_pwm;

    logic [WIDTH-1:0]        w_cnt_nxt;
    logic                    w_dir_down_nxt;
    logic                    w_tick;
    logic                    w_boundary;
    logic [NUM_CH-1:0]       w_raw;

    // Next counter value and direction, applied only on a prescaler tick.
    always_comb begin
        w_cnt_nxt      = r_cnt;
        w_dir_down_nxt = r_dir_down;
        if (!r_center) begin
            // Edge-aligned: 0..P then wrap.
            if (r_cnt >= r_period) begin
                w_cnt_nxt = '0;
            end else begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
        end else if (!r_dir_down) begin
            // Center-aligned, counting up: turn around at P.
            if (r_cnt >= r_period) begin
                w_cnt_nxt      = (r_cnt == '0) ? '0 : (r_cnt - c_CNT_ONE);
                w_dir_down_nxt = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
        end else begin
            // Center-aligned, counting down toward 0.
            w_cnt_nxt = (r_cnt == '0) ? '0 : (r_cnt - c_CNT_ONE);
        end
        // Every new period starts counting up (also covers P=0 and P=1).
        if (w_cnt_nxt == '0) begin
            w_dir_down_nxt = 1'b0;
        end
    end

    assign w_tick     = enable && (r_presc_cnt == prescale);
    assign w_boundary = w_tick && (w_cnt_nxt == '0);

    // Prescaler, period counter and count direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc_cnt <= '0;
            r_cnt       <= '0;
            r_dir_down  <= 1'b0;
        end else if (!enable) begin
            r_presc_cnt <= '0;
            r_cnt       <= '0;
            r_dir_down  <= 1'b0;
        end else if (w_tick) begin
            r_presc_cnt <= '0;
            r_cnt       <= w_cnt_nxt;
            r_dir_down  <= w_dir_down_nxt;
        end else begin
            r_presc_cnt <= r_presc_cnt + c_PRESC_ONE;
        end
    end

    // Shadow duty capture; a write always lands in the shadow bank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow <= '0;
        end else if (duty_wr) begin
            r_shadow <= duty_in;
        end
    end

    // Active configuration transfer at boundaries (or continuously when idle).
    // A write coinciding with the transfer goes straight through to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_active  <= '0;
            r_period  <= '0;
            r_center  <= 1'b0;
            r_pending <= 1'b0;
        end else if (!enable || w_boundary) begin
            r_active  <= duty_wr ? duty_in : r_shadow;
            r_period  <= period;
            r_center  <= center_mode;
            r_pending <= 1'b0;
        end else if (duty_wr) begin
            r_pending <= 1'b1;
        end
    end

    // Per-channel unsigned compare against the shared counter.
    generate
        for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
            assign w_raw[n] = (r_cnt < r_active[n*WIDTH +: WIDTH]);
        end
    endgenerate

    // Registered outputs: PWM levels with polarity, and the period-start pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_pwm          <= enable ? (w_raw ^ polarity) : polarity;
            r_period_start <= w_boundary;
        end
    end

    assign pwm_out        = r_pwm;
    assign period_start   = r_period_start;
    assign update_pending = r_pending;

endmodule
`default_nettype wire

// File: tb/tb_pwm_multi_channel.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_multi_channel
//  Description : Scoreboard bench for pwm_multi_channel. Each expected period
//                (length, per-channel high count, level at count 0) is queued
//                by the stimulus; a monitor measures every period between
//                period_start pulses and compares against the queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_multi_channel;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [7:0]  prescale = '0;
    logic [7:0]  period = '0;
    logic        center_mode = 1'b0;
    logic        duty_wr = 1'b0;
    logic [31:0] duty_in = '0;
    logic [3:0]  polarity = '0;
    logic [3:0]  pwm_out;
    logic        period_start;
    logic        update_pending;

    pwm_multi_channel #(.NUM_CH(4), .WIDTH(8), .PRESCALE_W(8)) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .enable         (enable),
        .prescale       (prescale),
        .period         (period),
        .center_mode    (center_mode),
        .duty_wr        (duty_wr),
        .duty_in        (duty_in),
        .polarity       (polarity),
        .pwm_out        (pwm_out),
        .period_start   (period_start),
        .update_pending (update_pending)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int              len;
        logic [3:0][7:0] hi;
        logic [3:0]      first;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   win_cnt  = 0;
    int   win_len  = 0;
    int   hi_cnt[4];
    logic [3:0] first_s = '0;
    logic ps_prev = 1'b0;

    task automatic chk(input string nm, input int act, input int exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_fail++;
            $display("FAIL %s actual=%0d expected=%0d @%0t", nm, act, exp_v, $time);
        end
    endtask

    task automatic push(input int len, input int h0, input int h1, input int h2,
                        input int h3, input logic [3:0] f);
        exp_t e;
        e.len   = len;
        e.hi[0] = h0[7:0];
        e.hi[1] = h1[7:0];
        e.hi[2] = h2[7:0];
        e.hi[3] = h3[7:0];
        e.first = f;
        sb.push_back(e);
    endtask

    // Monitor: a window opens one sample after each period_start pulse, so it
    // covers exactly the outputs produced from one counter period.
    always @(negedge clk) begin
        exp_t e;
        if (ps_prev) begin
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("period_len", win_len, e.len);
                for (int ch = 0; ch < 4; ch++) begin
                    chk($sformatf("high_ticks_ch%0d", ch), hi_cnt[ch], int'(e.hi[ch]));
                end
                chk("level_at_cnt0", int'(first_s), int'(e.first));
            end
            win_cnt++;
            win_len = 0;
            for (int ch = 0; ch < 4; ch++) hi_cnt[ch] = 0;
            first_s = pwm_out;
        end
        win_len++;
        for (int ch = 0; ch < 4; ch++) hi_cnt[ch] += int'(pwm_out[ch]);
        ps_prev = period_start;
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic wait_win(input int n);
        int tgt;
        int i;
        tgt = win_cnt + n;
        i   = 0;
        while (win_cnt < tgt && i < 500) begin
            step(1);
            i++;
        end
        chk("window_wait", int'(win_cnt >= tgt), 1);
    endtask

    task automatic drain();
        int i;
        i = 0;
        while (sb.size() > 0 && i < 400) begin
            step(1);
            i++;
        end
        chk("queue_drained", sb.size(), 0);
        sb.delete();
    endtask

    task automatic write_duty(input logic [31:0] d);
        duty_in = d;
        duty_wr = 1'b1;
        step(1);
        duty_wr = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        for (int ch = 0; ch < 4; ch++) hi_cnt[ch] = 0;
        // Reset state
        step(2);
        chk("rst_pwm_out", int'(pwm_out), 0);
        chk("rst_period_start", int'(period_start), 0);
        chk("rst_update_pending", int'(update_pending), 0);
        rst_n = 1'b1;
        step(1);

        // 1: edge, P=9, prescale 0, duty {255,10,3,0}
        prescale = 8'd0; period = 8'd9; center_mode = 1'b0; polarity = 4'h0;
        write_duty({8'd255, 8'd10, 8'd3, 8'd0});
        enable = 1'b1;
        wait_win(2);
        push(10, 0, 3, 10, 10, 4'b1110);
        push(10, 0, 3, 10, 10, 4'b1110);
        drain();

        // 2: edge, P=3, prescale 2, duty {1,4,0,2}
        prescale = 8'd2; period = 8'd3;
        write_duty({8'd1, 8'd4, 8'd0, 8'd2});
        wait_win(2);
        push(12, 6, 0, 12, 3, 4'b1101);
        push(12, 6, 0, 12, 3, 4'b1101);
        drain();

        // 3: double-buffered mid-period write, then write on boundary cycle
        prescale = 8'd0; period = 8'd9;
        write_duty({8'd255, 8'd10, 8'd3, 8'd0});
        wait_win(2);
        wait_win(1);                 // counter is at 1 now
        push(10, 0, 3, 10, 10, 4'b1110);
        push(10, 0, 5, 10, 10, 4'b1110);
        step(3);                     // counter at 4
        write_duty({8'd255, 8'd10, 8'd5, 8'd0});
        chk("pending_after_mid_write", int'(update_pending), 1);
        step(5);                     // first cycle of next period
        chk("pending_cleared_at_boundary", int'(update_pending), 0);
        chk("period_start_pulse", int'(period_start), 1);
        wait_win(1);                 // counter at 1 of the duty-5 period
        step(8);                     // counter at 9: boundary cycle
        push(10, 0, 7, 10, 10, 4'b1110);
        write_duty({8'd255, 8'd10, 8'd7, 8'd0});
        chk("pending_write_through", int'(update_pending), 0);
        drain();

        // 4: center, P=4, duty {5,4,0,2}
        center_mode = 1'b1; period = 8'd4;
        write_duty({8'd5, 8'd4, 8'd0, 8'd2});
        wait_win(2);
        push(8, 3, 0, 7, 8, 4'b1101);
        push(8, 3, 0, 7, 8, 4'b1101);
        drain();

        // 5: polarity inverted, idle level and extreme duties
        enable = 1'b0; center_mode = 1'b0; period = 8'd9; polarity = 4'hF;
        write_duty({8'd0, 8'd3, 8'd10, 8'd0});
        step(1);
        chk("idle_level_pol", int'(pwm_out), 15);
        chk("idle_pending", int'(update_pending), 0);
        chk("idle_period_start", int'(period_start), 0);
        enable = 1'b1;
        step(1);
        chk("first_enabled_level", int'(pwm_out), 9);
        wait_win(2);
        push(10, 10, 0, 7, 10, 4'b1001);
        push(10, 10, 0, 7, 10, 4'b1001);
        drain();

        // 6: reset mid-period with a pending write
        polarity = 4'b1010;
        wait_win(1);
        step(2);
        write_duty({8'd3, 8'd3, 8'd3, 8'd3});
        chk("pending_before_reset", int'(update_pending), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_pwm_out", int'(pwm_out), 0);
        chk("async_rst_pending", int'(update_pending), 0);
        chk("async_rst_period_start", int'(period_start), 0);
        enable = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        chk("post_reset_idle_level", int'(pwm_out), 10);
        enable = 1'b1;
        wait_win(2);
        push(10, 0, 10, 0, 10, 4'b1010);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
